// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Brief    : Shared types and constants for the block-copy DMA engine.
// Revision : 1.0  initial release
// ============================================================================
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } dma_state_t;

    localparam int CMD_START_BIT = 31;
    localparam int WORD_BYTES    = 4;

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : dma_addr_gen
// Brief    : Combinational source/destination address generator with range flag.
// Revision : 1.0  initial release
// ============================================================================
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int           N        = 32,
    parameter int           CW       = 18,
    parameter logic [N-1:0] SRC_BASE = 32'h0000_0000,
    parameter logic [N-1:0] DST_BASE = 32'h0001_0000,
    parameter logic [N-1:0] MAX_ADDR = 32'h0003_D08F
) (
    input  logic [CW-1:0] idx,
    output logic [N-1:0]  src_addr,
    output logic [N-1:0]  dst_addr,
    output logic          out_of_range
);

    localparam int c_shift = $clog2(WORD_BYTES);

    logic [N-1:0] w_offset;

    assign w_offset     = N'(idx) << c_shift;
    assign src_addr     = SRC_BASE + w_offset;
    assign dst_addr     = DST_BASE + w_offset;
    assign out_of_range = (src_addr > MAX_ADDR) || (dst_addr > MAX_ADDR);

endmodule : dma_addr_gen
`default_nettype wire

// File: rtl/dma_copy_unit.sv
`default_nettype none
// ============================================================================
// Module   : dma_copy_unit
// Brief    : Command-triggered block-copy DMA driving the second memory port.
// Revision : 1.0  initial release
// ============================================================================
module dma_copy_unit
    import dma_pkg::*;
#(
    parameter int           N        = 32,
    parameter int           CW       = 18,
    parameter logic [N-1:0] SRC_BASE = 32'h0000_0000,
    parameter logic [N-1:0] DST_BASE = 32'h0001_0000,
    parameter logic [N-1:0] MAX_ADDR = 32'h0003_D08F
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  cmd,
    input  logic [N-1:0]  rd_data,
    output logic [N-1:0]  mem_address,
    output logic [N-1:0]  mem_wdata,
    output logic          mem_wen,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] words_done
);

    dma_state_t    r_state;
    logic          r_start_q;
    logic          r_armed;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_words_done;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic          w_start;
    logic [N-1:0]  w_src_addr;
    logic [N-1:0]  w_dst_addr;
    logic          w_out_of_range;
    logic          w_unused_cmd;

    // r_armed masks the reset value of r_start_q so a start level held across
    // reset is not mistaken for a fresh rising edge.
    assign w_start      = cmd[CMD_START_BIT] & ~r_start_q & r_armed;
    assign w_unused_cmd = &{1'b0, cmd[N-2:CW]};

    dma_addr_gen #(
        .N        (N),
        .CW       (CW),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE),
        .MAX_ADDR (MAX_ADDR)
    ) u_addr_gen (
        .idx          (r_words_done),
        .src_addr     (w_src_addr),
        .dst_addr     (w_dst_addr),
        .out_of_range (w_out_of_range)
    );

    always_comb begin
        mem_address = '0;
        mem_wdata   = '0;
        mem_wen     = 1'b0;
        case (r_state)
            ST_RD: begin
                mem_address = w_src_addr;
            end
            ST_WR: begin
                mem_address = w_dst_addr;
                mem_wdata   = rd_data;
                mem_wen     = 1'b1;
            end
            default: begin
                mem_address = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_start_q    <= 1'b0;
            r_armed      <= 1'b0;
            r_len        <= '0;
            r_words_done <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_start_q <= cmd[CMD_START_BIT];
            if (!cmd[CMD_START_BIT]) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_len        <= cmd[CW-1:0];
                        r_words_done <= '0;
                        r_err        <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (r_words_done == r_len) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                        r_state <= ST_DONE;
                    end else if (w_out_of_range) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_state <= ST_WR;
                end
                ST_WR: begin
                    r_words_done <= r_words_done + CW'(1);
                    r_state      <= ST_CHECK;
                end
                ST_DONE: begin
                    if (!cmd[CMD_START_BIT]) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign words_done = r_words_done;

endmodule : dma_copy_unit
`default_nettype wire

// File: tb/tb_dma_copy_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dma_copy_unit
// Brief    : Two DMA instances (nominal and near-top destination) against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dma_copy_unit;

    localparam logic [31:0] c_src  = 32'h0000_0000;
    localparam logic [31:0] c_max  = 32'h0003_D08F;
    localparam logic [31:0] c_dst0 = 32'h0001_0000;
    localparam logic [31:0] c_dst1 = 32'h0003_D084;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;

    logic [31:0] rd_data     [2];
    logic [31:0] mem_address [2];
    logic [31:0] mem_wdata   [2];
    logic        mem_wen     [2];
    logic        busy        [2];
    logic        done        [2];
    logic        err         [2];
    logic [17:0] words_done  [2];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dma_copy_unit #(.DST_BASE(c_dst0)) u_dut0 (
        .clk(clk), .rst(rst), .cmd(cmd), .rd_data(rd_data[0]),
        .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]), .mem_wen(mem_wen[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]), .words_done(words_done[0])
    );

    dma_copy_unit #(.DST_BASE(c_dst1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd(cmd), .rd_data(rd_data[1]),
        .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]), .mem_wen(mem_wen[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]), .words_done(words_done[1])
    );

    // Memory contents: the first four source words are fixed, the rest a pattern.
    function automatic logic [31:0] memval(input logic [31:0] addr);
        if (addr[31:4] == 28'd0) begin
            case (addr[3:2])
                2'd0:    return 32'd11;
                2'd1:    return 32'd22;
                2'd2:    return 32'd33;
                default: return 32'd44;
            endcase
        end
        return addr ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk) begin
        rd_data[0] <= memval(mem_address[0]);
        rd_data[1] <= memval(mem_address[1]);
    end

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    int          log_cnt1 = 0;

    initial forever begin
        @(posedge clk);
        if (mem_wen[0]) begin
            log_addr.push_back(mem_address[0]);
            log_data.push_back(mem_wdata[0]);
        end
        if (mem_wen[1]) log_cnt1++;
    end

    // ---------------- behavioural model ----------------
    int          m_mode    [2];   // 0 idle, 1 running, 2 done
    int          m_t       [2];   // cycles since the start cycle
    int          m_k       [2];   // words that will be copied
    logic [17:0] m_wd      [2];
    bit          m_err     [2];
    bit          m_prevlow [2];

    function automatic int legal_words(input logic [31:0] base);
        if (base > c_max) return 0;
        return int'((c_max - base) / 4) + 1;
    endfunction

    function automatic int words_copied(input logic [17:0] len, input logic [31:0] dst);
        int k;
        k = int'(len);
        if (legal_words(c_src) < k) k = legal_words(c_src);
        if (legal_words(dst) < k)   k = legal_words(dst);
        return k;
    endfunction

    function automatic logic [31:0] dst_of(input int j);
        return (j == 0) ? c_dst0 : c_dst1;
    endfunction

    initial begin
        for (int j = 0; j < 2; j++) begin
            m_mode[j] = 0; m_t[j] = 0; m_k[j] = 0;
            m_wd[j] = '0; m_err[j] = 1'b0; m_prevlow[j] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst);
            for (int j = 0; j < 2; j++) begin
                if (!rst) begin
                    m_mode[j] = 0; m_t[j] = 0; m_k[j] = 0;
                    m_wd[j] = '0; m_err[j] = 1'b0; m_prevlow[j] = 1'b0;
                end else begin
                    case (m_mode[j])
                        0: if (cmd[31] && m_prevlow[j]) begin
                            m_k[j]    = words_copied(cmd[17:0], dst_of(j));
                            m_err[j]  = (m_k[j] < int'(cmd[17:0]));
                            m_wd[j]   = '0;
                            m_t[j]    = 1;
                            m_mode[j] = 1;
                        end
                        1: begin
                            m_t[j] = m_t[j] + 1;
                            if (m_t[j] == 3 * m_k[j] + 2) begin
                                m_mode[j] = 2;
                                m_wd[j]   = 18'(m_k[j]);
                            end
                        end
                        default: if (!cmd[31]) m_mode[j] = 0;
                    endcase
                    m_prevlow[j] = !cmd[31];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        for (int j = 0; j < 2; j++) begin
            bit          e_busy, e_done, e_wen, e_rd;
            logic [31:0] e_addr, e_wdata;
            logic [17:0] e_wd;
            int          u, k, p;
            e_busy = 0; e_done = 0; e_wen = 0; e_rd = 0;
            e_addr = '0; e_wdata = '0; e_wd = m_wd[j];
            if (m_mode[j] == 1) begin
                u = m_t[j] - 1; k = u / 3; p = u % 3;
                e_busy = 1;
                e_wd   = 18'(k);
                if (k < m_k[j] && p == 1) begin
                    e_rd = 1; e_addr = c_src + 32'(4 * k);
                end
                if (k < m_k[j] && p == 2) begin
                    e_wen   = 1;
                    e_addr  = dst_of(j) + 32'(4 * k);
                    e_wdata = memval(c_src + 32'(4 * k));
                end
            end
            if (m_mode[j] == 2) e_done = 1;
            chk($sformatf("busy%0d", j), 32'(busy[j]), 32'(e_busy));
            chk($sformatf("done%0d", j), 32'(done[j]), 32'(e_done));
            chk($sformatf("wen%0d", j), 32'(mem_wen[j]), 32'(e_wen));
            chk($sformatf("words_done%0d", j), 32'(words_done[j]), 32'(e_wd));
            if (e_done) chk($sformatf("err%0d", j), 32'(err[j]), 32'(m_err[j]));
            if (e_rd || e_wen) chk($sformatf("addr%0d", j), mem_address[j], e_addr);
            if (e_wen) chk($sformatf("wdata%0d", j), mem_wdata[j], e_wdata);
        end
    endtask

    initial forever begin
        @(negedge clk);
        check_cycle();
    end

    // Returns the cycle (relative to the start cycle) where done[j] first rises, or -1.
    task automatic wait_done(input int j, input int limit, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit && cyc < 0; c++) begin
            @(negedge clk);
            if (done[j]) cyc = c;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst = 1'b0;
        cmd = 32'h8000_0004;

        // Reset with start held high: outputs zero, no transfer after release.
        idle_cycles(3);
        chk("rst_wen", 32'(mem_wen[0]), 32'd0);
        chk("rst_addr", mem_address[0], 32'd0);
        chk("rst_err", 32'(err[0]), 32'd0);
        rst = 1'b1;
        idle_cycles(6);
        chk("rst_release_busy", 32'(busy[0]), 32'd0);
        chk("rst_release_done", 32'(done[0]), 32'd0);

        // Nominal 4-word copy; instance 1 aborts near the top of memory.
        cmd = 32'h0;
        idle_cycles(2);
        log_addr.delete(); log_data.delete(); log_cnt1 = 0;
        cmd = 32'h8000_0004;
        wait_done(0, 40, cyc);
        chk("nom_done_cycle", 32'(cyc), 32'd14);
        chk("nom_words_done", 32'(words_done[0]), 32'd4);
        chk("nom_err", 32'(err[0]), 32'd0);
        chk("rng_done", 32'(done[1]), 32'd1);
        chk("rng_err", 32'(err[1]), 32'd1);
        chk("rng_words_done", 32'(words_done[1]), 32'd3);
        chk("rng_writes", 32'(log_cnt1), 32'd3);
        chk("nom_nwrites", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            chk($sformatf("nom_waddr%0d", i), log_addr[i], 32'h0001_0000 + 32'(4 * i));
            chk($sformatf("nom_wdata%0d", i), log_data[i], 32'(11 * (i + 1)));
        end
        idle_cycles(6);
        chk("hold_no_retrigger_busy", 32'(busy[0]), 32'd0);
        chk("hold_done_stays", 32'(done[0]), 32'd1);
        cmd = 32'h0;
        @(negedge clk);
        chk("done_drop", 32'(done[0]), 32'd0);
        idle_cycles(2);

        // Zero-length transfer.
        log_addr.delete(); log_cnt1 = 0;
        cmd = 32'h8000_0000;
        wait_done(0, 20, cyc);
        chk("zero_done_cycle", 32'(cyc), 32'd2);
        chk("zero_err", 32'(err[0]), 32'd0);
        chk("zero_nwrites", 32'(log_addr.size() + log_cnt1), 32'd0);
        cmd = 32'h0;
        idle_cycles(3);

        // Start pulse during WR is ignored.
        log_addr.delete();
        cmd = 32'h8000_0002;
        idle_cycles(3);
        cmd = 32'h0;
        @(negedge clk);
        cmd = 32'h8000_0002;
        wait_done(0, 30, cyc);
        chk("pulse_done_seen", 32'(cyc > 0), 32'd1);
        chk("pulse_words_done", 32'(words_done[0]), 32'd2);
        chk("pulse_nwrites", 32'(log_addr.size()), 32'd2);
        cmd = 32'h0;
        idle_cycles(3);

        // Async reset during the second WR of a 4-word copy.
        log_addr.delete();
        cmd = 32'h8000_0004;
        idle_cycles(6);
        chk("rst_mid_wen_before", 32'(mem_wen[0]), 32'd1);
        #1 rst = 1'b0;
        #1 chk("rst_mid_wen_after", 32'(mem_wen[0]), 32'd0);
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(10);
        chk("rst_mid_no_restart", 32'(busy[0]), 32'd0);
        chk("rst_mid_nwrites", 32'(log_addr.size()), 32'd1);

        // A fresh edge after reset starts a new transfer.
        cmd = 32'h0;
        idle_cycles(2);
        cmd = 32'h8000_0001;
        wait_done(0, 20, cyc);
        chk("fresh_done_cycle", 32'(cyc), 32'd5);
        cmd = 32'h0;
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_dma_copy_unit
`default_nettype wire
